// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and helpers for the sequential shift-and-add
//                multiplier family (state encoding, counter sizing).
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // State encodings, kept as named constants so other variants share them
  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_CALC_ENC = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_CALC = ST_CALC_ENC,
    ST_DONE = ST_DONE_ENC
  } state_e;

  // Ceiling log2; clog2(WIDTH+1) bits hold a count running from WIDTH to 0
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_add_step.sv
`default_nettype none
// ============================================================================
//  Module      : mult_add_step
//  Description : One partial-product step: conditionally adds the multiplicand,
//                shifted left by 'shift', into a double-width accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_add_step #(
  parameter int WIDTH    = 8,
  parameter int SHIFT_W  = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               add_bit,
  input  logic [SHIFT_W-1:0] shift,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] w_partial;

  // Zero-extend before shifting so no multiplicand bits are lost off the top
  assign w_partial = {{WIDTH{1'b0}}, mcand} << shift;

  // The accumulator is 2*WIDTH bits wide, so the sum of all partial products
  // of two WIDTH-bit operands always fits without wrapping
  always_comb begin
    acc_next = acc;
    if (add_bit) begin
      acc_next = acc + w_partial;
    end
  end

endmodule : mult_add_step
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_shift_add_multiplier
//  Description : Sequential unsigned shift-and-add multiplier with valid/ready
//                request (A, B) and response (P) ports. One operation in
//                flight; optional early exit when remaining multiplier bits
//                are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int             CW         = clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_CNT_INIT = CW'(WIDTH);

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] p_q,      p_d;

  logic [CW-1:0]      w_shift;
  logic [CW-1:0]      w_cnt_dec;
  logic [WIDTH-1:0]   w_mplier_shr;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last_step;

  // Bit position being processed: 0 on the first CALC cycle, WIDTH-1 on the last
  assign w_shift      = C_CNT_INIT - cnt_q;
  assign w_cnt_dec    = cnt_q - CW'(1);
  assign w_mplier_shr = mplier_q >> 1;
  assign w_last_step  = (w_cnt_dec == '0) ||
                        (EARLY_EXIT && (w_mplier_shr == '0));

  mult_add_step #(
    .WIDTH   (WIDTH),
    .SHIFT_W (CW)
  ) u_add_step (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .add_bit  (mplier_q[0]),
    .shift    (w_shift),
    .acc_next (w_acc_next)
  );

  // Next-state, datapath and handshake decisions
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      ST_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone completes the handshake
        if (in_valid) begin
          mcand_d  = A;
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = C_CNT_INIT;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = w_acc_next;
        mplier_d = w_mplier_shr;
        cnt_d    = w_cnt_dec;
        if (w_last_step) begin
          // P is loaded only here so it holds its last value through IDLE
          p_d     = w_acc_next;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign P         = p_q;

endmodule : seq_shift_add_multiplier
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_shift_add_multiplier
//  Description : Self-checking bench for seq_shift_add_multiplier. Three
//                instances: WIDTH=2, WIDTH=8, WIDTH=8 with early exit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic [2:0]  vld;
  logic [2:0]  rdy;
  logic [7:0]  a_s [3];
  logic [7:0]  b_s [3];
  logic [2:0]  in_ready_s;
  logic [2:0]  out_valid_s;
  logic [2:0]  busy_s;
  logic [3:0]  p_w2;
  logic [15:0] p_w8;
  logic [15:0] p_w8e;
  logic [15:0] p_s [3];

  int checks;
  int errors;

  typedef struct {
    int          d;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  seq_shift_add_multiplier #(.WIDTH(2), .EARLY_EXIT(1'b0)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(in_ready_s[0]),
    .A(a_s[0][1:0]), .B(b_s[0][1:0]), .out_valid(out_valid_s[0]),
    .out_ready(rdy[0]), .P(p_w2), .busy(busy_s[0])
  );

  seq_shift_add_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(in_ready_s[1]),
    .A(a_s[1]), .B(b_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(rdy[1]), .P(p_w8), .busy(busy_s[1])
  );

  seq_shift_add_multiplier #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8e (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(in_ready_s[2]),
    .A(a_s[2]), .B(b_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(rdy[2]), .P(p_w8e), .busy(busy_s[2])
  );

  always_comb begin
    p_s[0] = {12'b0, p_w2};
    p_s[1] = p_w8;
    p_s[2] = p_w8e;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: product by plain arithmetic on the operands as seen by each instance
  function automatic logic [15:0] ref_prod(input int d, input logic [7:0] a, input logic [7:0] b);
    int wa;
    int wb;
    wa = (d == 0) ? int'(a[1:0]) : int'(a);
    wb = (d == 0) ? int'(b[1:0]) : int'(b);
    return 16'(wa * wb);
  endfunction

  // Reference latency: fixed WIDTH, or position of B's top set bit + 1 with early exit
  function automatic int ref_lat(input int d, input logic [7:0] b);
    int top;
    if (d == 0) return 2;
    if (d == 1) return 8;
    top = 1;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) top = i + 1;
    end
    return top;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One complete request/response; lat counts cycles from the accepting edge to out_valid
  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_s[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    vld[d] = 1'b1;
    a_s[d] = a;
    b_s[d] = b;
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    lat = 0;
    while (!out_valid_s[d] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = p_s[d];
  endtask

  initial begin
    logic [15:0] p;
    int          lat;
    logic [7:0]  ra;
    logic [7:0]  rb;
    int          rd;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    vld    = 3'b000;
    rdy    = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a_s[i] = 8'h00;
      b_s[i] = 8'h00;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_in_ready[%0d]", i), in_ready_s[i], 1);
      check($sformatf("reset_out_valid[%0d]", i), out_valid_s[i], 0);
      check($sformatf("reset_busy[%0d]", i), busy_s[i], 0);
      check($sformatf("reset_p[%0d]", i), p_s[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: {instance, A, B, expected P, expected latency}
    vecs[0] = '{0, 8'd2,   8'd3,    16'd6,     2};
    vecs[1] = '{0, 8'd3,   8'd3,    16'd9,     2};
    vecs[2] = '{1, 8'd255, 8'd255,  16'd65025, 8};
    vecs[3] = '{1, 8'd0,   8'd200,  16'd0,     8};
    vecs[4] = '{2, 8'd77,  8'd1,    16'd77,    1};
    vecs[5] = '{2, 8'd5,   8'h80,   16'd640,   8};
    vecs[6] = '{2, 8'd99,  8'd0,    16'd0,     1};
    vecs[7] = '{2, 8'd3,   8'h10,   16'd48,    5};
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, p, lat);
      check($sformatf("vec%0d_p", i), p, vecs[i].p);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Exhaustive 2-bit sweep, back-to-back
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        run_op(0, 8'(a), 8'(b), p, lat);
        check($sformatf("sweep_%0dx%0d_p", a, b), p, a * b);
        check($sformatf("sweep_%0dx%0d_lat", a, b), lat, 2);
      end
    end

    // Random operations across all instances
    for (int i = 0; i < 40; i++) begin
      rd = int'($urandom_range(0, 2));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ((i % 5) == 0) rb = rb >> $urandom_range(0, 7);
      run_op(rd, ra, rb, p, lat);
      check($sformatf("rand%0d_d%0d_%0dx%0d_p", i, rd, ra, rb), p, ref_prod(rd, ra, rb));
      check($sformatf("rand%0d_d%0d_lat", i, rd), lat, ref_lat(rd, rb));
    end

    // Backpressure: hold DONE for 20 cycles, try a request meanwhile
    rdy[1] = 1'b0;
    run_op(1, 8'd13, 8'd11, p, lat);
    check("bp_first_p", p, 143);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        vld[1] = 1'b1;
        a_s[1] = 8'd1;
        b_s[1] = 8'd1;
      end
      if (i == 10) vld[1] = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_p", i), p_s[1], 143);
      check($sformatf("bp_hold%0d_valid", i), out_valid_s[1], 1);
      check($sformatf("bp_hold%0d_in_ready", i), in_ready_s[1], 0);
    end
    rdy[1] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid_s[1], 0);
    check("bp_release_in_ready", in_ready_s[1], 1);
    repeat (10) @(posedge clk);
    #1;
    check("bp_no_queue_busy", busy_s[1], 0);
    check("bp_no_queue_valid", out_valid_s[1], 0);
    check("bp_p_kept", p_s[1], 143);

    // Reset three cycles into an operation
    @(negedge clk);
    vld[1] = 1'b1;
    a_s[1] = 8'd200;
    b_s[1] = 8'd255;
    @(posedge clk);
    #1;
    vld[1] = 1'b0;
    check("midop_busy", busy_s[1], 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_rst_valid", out_valid_s[1], 0);
    check("midop_rst_p", p_s[1], 0);
    check("midop_rst_in_ready", in_ready_s[1], 1);
    check("midop_rst_busy", busy_s[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midop_no_stale_valid", out_valid_s[1], 0);
    run_op(1, 8'd7, 8'd9, p, lat);
    check("midop_fresh_p", p, 63);
    check("midop_fresh_lat", lat, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seq_shift_add_multiplier
`default_nettype wire
